// File: rtl/admin_cfg_editor.sv
// Cursor-based BCD editor for NUM_FIELDS config words, with press-and-hold auto-repeat.
// Edits land in a shadow copy that is committed atomically on the final confirm.
module admin_cfg_editor #(
  parameter int NUM_FIELDS    = 5,
  parameter int DIGITS        = 3,
  parameter int REPEAT_CYCLES = 66000000,
  localparam int W    = 4 * DIGITS,
  localparam int FW   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CNTW = $clog2(REPEAT_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  on,
  input  logic [NUM_FIELDS*W-1:0] cfg_old,
  input  logic                  p_inc,
  input  logic                  p_dec,
  input  logic                  l_pos,
  input  logic                  r_pos,
  input  logic                  m_pos,
  input  logic                  d_pos,
  input  logic                  u_pos,
  output logic [NUM_FIELDS*W-1:0] cfg_new,
  output logic                  commit,
  output logic                  busy,
  output logic [FW-1:0]         field_idx,
  output logic [CW-1:0]         cursor,
  output logic [W-1:0]          edit_value
);

  // state  | meaning
  // IDLE   | admin mode off, committed config held
  // LOAD   | copy cfg_old into the shadow, home field/cursor
  // EDIT   | cursor moves and digit steps on the shadow
  // COMMIT | shadow has just been written to cfg_new; commit strobe high
  typedef enum logic [1:0] {IDLE, LOAD, EDIT, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic [NUM_FIELDS*W-1:0] shadow_q, shadow_d;
  logic [NUM_FIELDS*W-1:0] cfg_q, cfg_d;
  logic [FW-1:0]           field_q, field_d;
  logic [CW-1:0]           cursor_q, cursor_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic                    inc_prev, dec_prev;
  logic                    inc_act, dec_act, step;
  logic [3:0]              digit;
  int                      sel;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  assign inc_act = p_inc & ~p_dec;
  assign dec_act = p_dec & ~p_inc;
  assign sel     = int'(field_q) * W + int'(cursor_q) * 4;
  assign digit   = shadow_q[sel +: 4];

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    field_d  = field_q;
    cursor_d = cursor_q;
    cnt_d    = '0;
    step     = 1'b0;
    case (state_q)
      IDLE: if (on) state_d = LOAD;
      LOAD: begin
        shadow_d = cfg_old;
        field_d  = '0;
        cursor_d = '0;
        state_d  = EDIT;
      end
      EDIT: begin
        if (!on || u_pos) begin
          state_d  = IDLE;
          shadow_d = '0;
        end else if (m_pos) begin
          cursor_d = '0;
          if (field_q == FW'(NUM_FIELDS - 1)) begin
            state_d = COMMIT;
            cfg_d   = shadow_q;
          end else begin
            field_d = field_q + 1'b1;
          end
        end else if (d_pos) begin
          cursor_d = '0;
          if (field_q != '0) field_d = field_q - 1'b1;
        end else begin
          if (l_pos && !r_pos && cursor_q != CW'(DIGITS - 1))
            cursor_d = cursor_q + 1'b1;
          else if (r_pos && !l_pos && cursor_q != '0)
            cursor_d = cursor_q - 1'b1;
          // fresh press steps at once; a held press steps every REPEAT_CYCLES
          if (inc_act || dec_act) begin
            if ((inc_act && !inc_prev) || (dec_act && !dec_prev))
              step = 1'b1;
            else if (cnt_q == CNTW'(REPEAT_CYCLES - 1))
              step = 1'b1;
            else
              cnt_d = cnt_q + 1'b1;
            if (step) shadow_d[sel +: 4] = inc_act ? bcd_inc(digit) : bcd_dec(digit);
          end
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      cfg_q    <= '0;
      field_q  <= '0;
      cursor_q <= '0;
      cnt_q    <= '0;
      inc_prev <= 1'b0;
      dec_prev <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      field_q  <= field_d;
      cursor_q <= cursor_d;
      cnt_q    <= cnt_d;
      inc_prev <= inc_act;
      dec_prev <= dec_act;
    end
  end

  assign cfg_new    = cfg_q;
  assign commit     = (state_q == COMMIT);
  assign busy       = (state_q == LOAD) || (state_q == EDIT);
  assign field_idx  = field_q;
  assign cursor     = cursor_q;
  assign edit_value = (state_q == IDLE) ? '0 : shadow_q[int'(field_q) * W +: W];

endmodule
